// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC generation, synchronous SRAM request and
// a one-entry buffer that holds the fetched word while decode is stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  localparam logic [31:0] PC_BEFORE_RESET = RESET_PC - 32'd4;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        to_fs_valid;
  logic        to_fs_ready_go;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fs_load;
  logic [31:0] inst;

  assign {br_stall, br_taken, br_target} = br_bus;

  // Pre-IF: pick the next request address
  assign seq_pc         = pc_inc(fs_pc_q);
  assign nextpc         = br_taken ? br_target : seq_pc;
  assign to_fs_valid    = resetn;
  assign to_fs_ready_go = ~br_stall;

  // IF handshake with decode
  assign fs_ready_go    = 1'b1;
  assign fs_allowin     = ~fs_valid_q | (fs_ready_go & ds_allowin);
  assign fs_to_ds_valid = fs_valid_q & fs_ready_go;
  assign fs_load        = to_fs_valid & to_fs_ready_go & fs_allowin;

  assign inst_sram_en    = fs_load;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  // SRAM data is only valid for one cycle; the buffer covers decode stalls
  assign inst         = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
  assign fs_to_ds_bus = {inst, fs_pc_q};

  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    inst_buf_valid_d = inst_buf_valid_q;
    inst_buf_d       = inst_buf_q;

    if (fs_load) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = nextpc;
    end else if (fs_allowin) begin
      fs_valid_d = 1'b0;
    end

    if (fs_valid_q && ds_allowin) begin
      inst_buf_valid_d = 1'b0;
    end else if (fs_valid_q && !ds_allowin && !inst_buf_valid_q) begin
      inst_buf_valid_d = 1'b1;
      inst_buf_d       = inst_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= PC_BEFORE_RESET;
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= 32'h0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage against a slot-level model of
// the fetch stage and an address-derived instruction memory.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clk;
  logic        resetn;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  logic        corrupt;
  logic [31:0] sram_q;

  int total;
  int bad;

  // model state: the instruction slot held in IF
  logic        m_valid;
  logic [31:0] m_pc;
  logic        chk_on;
  logic        prev_hold;

  logic        obs_en;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [63:0] obs_bus;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ds_allowin     (ds_allowin),
    .br_bus         (br_bus),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5a5a_5a5a;
  endfunction

  always @(posedge clk) begin
    if (inst_sram_en) sram_q <= mem(inst_sram_addr);
  end
  assign inst_sram_rdata = corrupt ? 32'hdead_beef : sram_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rn, input logic al, input logic st, input logic tk,
                      input logic [31:0] tg, input logic cor);
    logic        e_en;
    logic [31:0] e_addr;
    resetn     = rn;
    ds_allowin = al;
    br_bus     = {st, tk, tg};
    corrupt    = cor;
    @(negedge clk);
    obs_en    = inst_sram_en;
    obs_addr  = inst_sram_addr;
    obs_valid = fs_to_ds_valid;
    obs_bus   = fs_to_ds_bus;
    e_en   = rn & ~st & (~m_valid | al);
    e_addr = tk ? tg : m_pc + 32'd4;
    if (chk_on) begin
      chk("valid", {63'd0, obs_valid}, {63'd0, m_valid});
      chk("pc", {32'd0, obs_bus[31:0]}, {32'd0, m_pc});
      if (m_valid) chk("inst", {32'd0, obs_bus[63:32]}, {32'd0, mem(m_pc)});
      chk("en", {63'd0, obs_en}, {63'd0, e_en});
      if (e_en || (!rn && !tk)) chk("addr", {32'd0, obs_addr}, {32'd0, e_addr});
      chk("wen_wdata", {28'd0, inst_sram_wen, inst_sram_wdata}, 64'd0);
    end
    prev_hold = rn & ~al & m_valid;
    if (!rn) begin
      m_valid = 1'b0;
      m_pc    = RESET_PC - 32'd4;
    end else if (e_en) begin
      m_valid = 1'b1;
      m_pc    = e_addr;
    end else if (!m_valid || al) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic rn, input logic al);
    step(rn, al, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    logic        rn, al, st, tk, cor;
    logic [31:0] tg;
    total = 0;
    bad = 0;
    chk_on = 1'b0;
    prev_hold = 1'b0;
    m_valid = 1'b0;
    m_pc = RESET_PC - 32'd4;
    corrupt = 1'b0;
    resetn = 1'b0;
    ds_allowin = 1'b1;
    br_bus = '0;
    @(posedge clk);
    #1;
    run(1'b0, 1'b1);
    chk_on = 1'b1;
    run(1'b0, 1'b1);
    chk("rst_valid", {63'd0, obs_valid}, 64'd0);
    chk("rst_en", {63'd0, obs_en}, 64'd0);
    chk("rst_pc", {32'd0, obs_bus[31:0]}, {32'd0, 32'hbfbf_fffc});
    chk("rst_addr", {32'd0, obs_addr}, {32'd0, 32'hbfc0_0000});

    // linear fetch then taken branch with delay slot at bfc00008
    run(1'b1, 1'b1);
    chk("lin_req0", {31'd0, obs_en, obs_addr}, {31'd0, 1'b1, 32'hbfc0_0000});
    run(1'b1, 1'b1);
    chk("lin_req1", {31'd0, obs_en, obs_addr}, {31'd0, 1'b1, 32'hbfc0_0004});
    chk("lin_out0", obs_bus, {mem(32'hbfc0_0000), 32'hbfc0_0000});
    run(1'b1, 1'b1);
    chk("lin_req2", {31'd0, obs_en, obs_addr}, {31'd0, 1'b1, 32'hbfc0_0008});
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'hbfc0_0100, 1'b0);
    chk("br_req", {31'd0, obs_en, obs_addr}, {31'd0, 1'b1, 32'hbfc0_0100});
    chk("br_slot", obs_bus, {mem(32'hbfc0_0008), 32'hbfc0_0008});
    run(1'b1, 1'b1);
    chk("br_tgt", obs_bus, {mem(32'hbfc0_0100), 32'hbfc0_0100});
    chk("br_seq", {32'd0, obs_addr}, {32'd0, 32'hbfc0_0104});

    // back-pressure with corrupted SRAM while IF holds bfc00004
    run(1'b0, 1'b1);
    run(1'b1, 1'b1);
    run(1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("bp_hold", obs_bus, {mem(32'hbfc0_0004), 32'hbfc0_0004});
    chk("bp_noreq", {63'd0, obs_en}, 64'd0);
    run(1'b1, 1'b1);
    chk("bp_release", {31'd0, obs_en, obs_addr}, {31'd0, 1'b1, 32'hbfc0_0008});

    // br_stall then redirect to bfc00200
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hbfc0_0300, 1'b0);
    chk("stall0_en", {63'd0, obs_en}, 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall1_en", {63'd0, obs_en}, 64'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'hbfc0_0200, 1'b0);
    chk("stall_redir", {31'd0, obs_en, obs_addr}, {31'd0, 1'b1, 32'hbfc0_0200});

    // reset during a buffered stall
    run(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    run(1'b0, 1'b0);
    run(1'b1, 1'b1);
    chk("mid_rst_valid", {63'd0, obs_valid}, 64'd0);
    chk("mid_rst_req", {31'd0, obs_en, obs_addr}, {31'd0, 1'b1, 32'hbfc0_0000});

    // PC wrap
    run(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'hffff_fffc, 1'b0);
    run(1'b1, 1'b1);
    chk("wrap_req", {31'd0, obs_en, obs_addr}, {31'd0, 1'b1, 32'h0000_0000});
    chk("wrap_out", obs_bus, {mem(32'hffff_fffc), 32'hffff_fffc});

    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 99) != 0);
      al = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 7) == 0);
      tk = ($urandom_range(0, 4) == 0);
      r  = $urandom;
      tg = ($urandom_range(0, 15) == 0) ? 32'hffff_fffc : {r[31:2], 2'b00};
      cor = prev_hold & rn & ~al & ($urandom_range(0, 1) == 1);
      step(rn, al, st, tk, tg, cor);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
